hour_counter_bcd: RTL and testbench
===================================

Name: hour_counter_bcd

Overview:
- Parameterised hour counter for the watch datapath; sits downstream of the minute counter and advances on its carry pulse.
- Holds the hour as a binary 0..23 value internally and presents it as two BCD digits in either 24-hour or 12-hour (AM/PM) format, selectable at run time.
- Adds over the previous generation:
  - advance enable;
  - synchronous time-set with validation;
  - AM/PM flag;
  - day-carry output for a future date block.

Parameters:
- RESET_HOUR, 0, internal hour (0..23) loaded on reset; values above 23 are a configuration error and the design clamps them to 0.
- DIGIT_W, 4, width of each BCD digit port; must be at least 4, and upper bits above 4 are driven 0.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle advance strobe (minute 59->00 carry)
- mode_12h  input  1  0 = 24-hour display, 1 = 12-hour display
- load  input  1  synchronous time-set strobe
- load_tens  input  DIGIT_W  BCD tens digit to set, in current mode's format
- load_ones  input  DIGIT_W  BCD ones digit to set
- load_pm  input  1  PM flag for set, used only when mode_12h=1
- hour_tens  output  DIGIT_W  BCD tens digit of displayed hour
- hour_ones  output  DIGIT_W  BCD ones digit of displayed hour
- pm  output  1  1 when internal hour is 12..23 (valid in both modes)
- day_carry  output  1  one-cycle pulse when hour wraps 23->0
- load_err  output  1  one-cycle pulse when a load value is rejected

Behaviour:
- Reset is asynchronous, active-low, with clock clk.
  - On rst=0: internal hour = RESET_HOUR; day_carry=0; load_err=0.
  - hour_tens, hour_ones and pm are set to the encoding of RESET_HOUR under the current mode_12h.
  - Default RESET_HOUR=0 gives 24h "00", pm=0, or 12h "12", pm=0.
- Internal state: h in 0..23, 5-bit binary. All outputs are registered and updated on the same edge as h.
- Priority each edge: load > tick > hold.
- Tick: h <= (h==23) ? 0 : h+1. day_carry=1 for exactly the cycle after the 23->0 edge, otherwise 0.
- Load validation, 24h mode:
  - accept tens 0..2 and ones 0..9 with tens*10+ones <= 23;
  - h <= tens*10+ones.
- Load validation, 12h mode:
  - accept 01..12;
  - h <= (value==12 ? 0 : value) + (load_pm ? 12 : 0).
- Load rejection:
  - any digit >9, DIGIT_W upper bits nonzero, or value out of range;
  - h unchanged, and load_err pulses for one cycle;
  - a tick in that same cycle is still applied, because a rejected load does not block tick.
- Load never raises day_carry, even when loading 0 from 23.
- Encode, 24h: tens = h/10, ones = h%10.
- Encode, 12h:
  - d = h mod 12;
  - displayed value = (d==0) ? 12 : d;
  - split into BCD. Tens digit is 0 or 1 only.
  - Sequence: 11 AM -> 12 PM at h 11->12; 11 PM -> 12 AM at h 23->0.
- pm = (h >= 12) in both modes.
- mode_12h change: h is unaffected. Outputs re-encode on the next rising edge (1-cycle latency) with no tick or carry side effect.
- tick and load held high across several cycles act on every cycle; there is no edge detection.

Decomposition:
- Shared package watch_pkg holds:
  - HOURS_PER_DAY=24 and HOURS_HALF=12 constants;
  - BCD digit typedef;
  - function bin_to_bcd2, which splits a 0..99 value into tens and ones digits (reused by the minute/second blocks).
- One natural sub-module: hour_encode, a combinational h + mode_12h -> tens/ones/pm encoder, instantiated once.

Test Plan:
- Reset, 24h mode: reset with mode_12h=0 -> 00, pm=0; 24 ticks -> sequence 01..23 then 00, with day_carry high only for the single cycle after 23->00.
- 12h rollover: mode_12h=1, from reset apply 12 ticks -> 01 AM .. 11 AM then 12 PM (pm=1). Continue 12 more ticks -> 12 AM, pm=0, day_carry pulse.
- 24h load: load 2,3 -> 23; load 2,4 -> hour stays 23, load_err pulses 1 cycle. Load 1,A -> rejected, load_err pulses.
- 12h load: load 1,2 with load_pm=0 -> 12 AM (h=0); load 0,0 -> rejected; load 0,7 with load_pm=1 -> 07 PM; switch to mode_12h=0 -> 19 one cycle later.
- Priority: at 23, assert load 0,5 and tick together -> 05, no day_carry. Invalid load together with tick at 22 -> 23 and load_err.
- Async reset mid-count: assert rst at h=15 between edges -> outputs 00 immediately, without a clock edge. Release with tick high -> 01 after the first edge following deassertion.

Source files
------------

// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : watch_pkg
//  Description : Shared constants, BCD types and helpers for the watch
//                datapath (hour / minute / second counters).
//  Revision    : 1.0 - initial release
// ============================================================================
package watch_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int HOURS_HALF    = 12;

  // One BCD digit, 0..9 in normal use.
  typedef logic [3:0] bcd_t;

  // Two-digit BCD pair, tens in the upper nibble.
  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  // Split a binary value 0..99 into its tens and ones BCD digits.
  function automatic bcd2_t bin_to_bcd2(input logic [6:0] value);
    bcd2_t r;
    int    v;
    v      = int'(value);
    r.tens = 4'(v / 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

endpackage : watch_pkg
`default_nettype wire

// File: rtl/hour_encode.sv
`default_nettype none
// ============================================================================
//  Module      : hour_encode
//  Description : Combinational encoder from the binary hour (0..23) to two
//                BCD display digits in 24-hour or 12-hour format, plus the
//                PM flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module hour_encode
  import watch_pkg::*;
(
  input  logic [4:0] h,
  input  logic       mode_12h,
  output bcd_t       tens,
  output bcd_t       ones,
  output logic       pm
);

  localparam logic [4:0] c_half = 5'(HOURS_HALF);

  logic [4:0] w_mod12;
  logic [4:0] w_disp12;
  logic [4:0] w_disp;
  bcd2_t      w_bcd;

  // Fold the hour into the 12-hour dial; hour 0 and hour 12 both read "12".
  always_comb begin
    w_mod12  = (h >= c_half) ? (h - c_half) : h;
    w_disp12 = (w_mod12 == 5'd0) ? c_half : w_mod12;
    w_disp   = mode_12h ? w_disp12 : h;
    w_bcd    = bin_to_bcd2({2'b00, w_disp});
    tens     = w_bcd.tens;
    ones     = w_bcd.ones;
    pm       = (h >= c_half);
  end

endmodule : hour_encode
`default_nettype wire

// File: rtl/hour_counter_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : hour_counter_bcd
//  Description : Hour counter advanced by the minute carry. Keeps the hour as
//                binary 0..23, supports validated synchronous time-set, and
//                presents registered BCD digits in 24h or 12h format with
//                PM flag, day-carry pulse and load-error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module hour_counter_bcd
  import watch_pkg::*;
#(
  parameter int unsigned RESET_HOUR = 0,
  parameter int unsigned DIGIT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               mode_12h,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_tens,
  input  logic [DIGIT_W-1:0] load_ones,
  input  logic               load_pm,
  output logic [DIGIT_W-1:0] hour_tens,
  output logic [DIGIT_W-1:0] hour_ones,
  output logic               pm,
  output logic               day_carry,
  output logic               load_err
);

  // Out-of-range reset hours fall back to midnight.
  localparam logic [4:0] c_reset_h =
    (RESET_HOUR >= HOURS_PER_DAY) ? 5'd0 : 5'(RESET_HOUR);
  localparam int    c_reset_mod  = int'(c_reset_h) % HOURS_HALF;
  localparam int    c_reset_d12  = (c_reset_mod == 0) ? HOURS_HALF : c_reset_mod;
  localparam bcd2_t c_reset_24   = bin_to_bcd2(7'(c_reset_h));
  localparam bcd2_t c_reset_12   = bin_to_bcd2(7'(c_reset_d12));
  localparam logic  c_reset_pm   = (int'(c_reset_h) >= HOURS_HALF);

  localparam logic [4:0] c_last_h = 5'(HOURS_PER_DAY - 1);
  localparam logic [6:0] c_half7  = 7'(HOURS_HALF);
  localparam logic [6:0] c_last7  = 7'(HOURS_PER_DAY - 1);

  logic [4:0] r_h;
  bcd_t       r_tens;
  bcd_t       r_ones;
  logic       r_pm;
  logic       r_day_carry;
  logic       r_load_err;

  logic       w_upper_zero;
  bcd_t       w_lt;
  bcd_t       w_lo;
  logic       w_digits_ok;
  logic [6:0] w_load_val;
  logic       w_range_ok;
  logic       w_load_ok;
  logic [4:0] w_base12;
  logic [4:0] w_load_h;
  logic [4:0] w_tick_h;
  logic [4:0] w_h_next;
  logic       w_carry_next;
  logic       w_err_next;
  bcd_t       w_enc_tens;
  bcd_t       w_enc_ones;
  logic       w_enc_pm;

  // Wide digit ports: upper bits of a load digit must be zero, and the
  // display digits are zero-extended.
  generate
    if (DIGIT_W > 4) begin : g_wide
      assign w_upper_zero = (load_tens[DIGIT_W-1:4] == '0) &&
                            (load_ones[DIGIT_W-1:4] == '0);
      assign hour_tens    = {{(DIGIT_W-4){1'b0}}, r_tens};
      assign hour_ones    = {{(DIGIT_W-4){1'b0}}, r_ones};
    end else begin : g_narrow
      assign w_upper_zero = 1'b1;
      assign hour_tens    = r_tens;
      assign hour_ones    = r_ones;
    end
  endgenerate

  assign w_lt = load_tens[3:0];
  assign w_lo = load_ones[3:0];

  // Validate the requested time and translate it to the internal 0..23 hour.
  always_comb begin
    w_digits_ok = w_upper_zero && (w_lt <= 4'd9) && (w_lo <= 4'd9);
    // tens*10 + ones; only meaningful when both digits are 0..9
    w_load_val  = {w_lt, 3'b000} + {2'b00, w_lt, 1'b0} + {3'b000, w_lo};
    if (mode_12h) begin
      w_range_ok = (w_load_val >= 7'd1) && (w_load_val <= c_half7);
    end else begin
      w_range_ok = (w_load_val <= c_last7);
    end
    w_load_ok = w_digits_ok && w_range_ok;
    // 12 AM is hour 0; PM adds half a day.
    w_base12  = (w_load_val == c_half7) ? 5'd0 : w_load_val[4:0];
    if (mode_12h) begin
      w_load_h = w_base12 + (load_pm ? 5'(HOURS_HALF) : 5'd0);
    end else begin
      w_load_h = w_load_val[4:0];
    end
  end

  assign w_tick_h = (r_h == c_last_h) ? 5'd0 : (r_h + 5'd1);

  // Next hour and pulses: accepted load wins, then tick, else hold.
  // A rejected load flags an error but does not block a same-cycle tick.
  always_comb begin
    w_h_next     = r_h;
    w_carry_next = 1'b0;
    w_err_next   = 1'b0;
    if (load && w_load_ok) begin
      w_h_next = w_load_h;
    end else begin
      w_err_next = load;
      if (tick) begin
        w_h_next     = w_tick_h;
        w_carry_next = (r_h == c_last_h);
      end
    end
  end

  // Encode the upcoming hour so the display registers update with r_h.
  hour_encode u_encode (
    .h        (w_h_next),
    .mode_12h (mode_12h),
    .tens     (w_enc_tens),
    .ones     (w_enc_ones),
    .pm       (w_enc_pm)
  );

  // State and registered outputs; reset display follows the current mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h         <= c_reset_h;
      r_tens      <= mode_12h ? c_reset_12.tens : c_reset_24.tens;
      r_ones      <= mode_12h ? c_reset_12.ones : c_reset_24.ones;
      r_pm        <= c_reset_pm;
      r_day_carry <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_h         <= w_h_next;
      r_tens      <= w_enc_tens;
      r_ones      <= w_enc_ones;
      r_pm        <= w_enc_pm;
      r_day_carry <= w_carry_next;
      r_load_err  <= w_err_next;
    end
  end

  assign pm        = r_pm;
  assign day_carry = r_day_carry;
  assign load_err  = r_load_err;

endmodule : hour_counter_bcd
`default_nettype wire

// File: tb/tb_hour_counter_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hour_counter_bcd
//  Description : Self-checking bench for hour_counter_bcd with a behavioural
//                hour model and directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hour_counter_bcd;

  localparam int DW = 6;
  localparam int RH = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          mode_12h;
  logic          load;
  logic [DW-1:0] load_tens;
  logic [DW-1:0] load_ones;
  logic          load_pm;
  logic [DW-1:0] hour_tens;
  logic [DW-1:0] hour_ones;
  logic          pm;
  logic          day_carry;
  logic          load_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // expected outputs from the model
  int m_h;
  int e_t, e_o;
  bit e_p, e_c, e_e;

  always #5 clk = ~clk;

  hour_counter_bcd #(.RESET_HOUR(RH), .DIGIT_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .mode_12h  (mode_12h),
    .load      (load),
    .load_tens (load_tens),
    .load_ones (load_ones),
    .load_pm   (load_pm),
    .hour_tens (hour_tens),
    .hour_ones (hour_ones),
    .pm        (pm),
    .day_carry (day_carry),
    .load_err  (load_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Display of an hour from its definition: 24h is the hour itself,
  // 12h shows 12 for hours 0 and 12.
  function automatic void enc(input int h, input bit m12,
                              output int t, output int o, output bit p);
    int v;
    v = m12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    t = v / 10;
    o = v % 10;
    p = (h >= 12);
  endfunction

  // One clock of the hour counter's rules.
  function automatic void step(input int h, input bit tk, input bit ld,
                               input bit m12, input int lt, input int lo,
                               input bit lpm, output int nh, output bit c,
                               output bit e);
    int  val;
    bit  ok;
    nh  = h;
    c   = 1'b0;
    e   = 1'b0;
    val = lt * 10 + lo;
    ok  = (lt <= 9) && (lo <= 9) &&
          (m12 ? (val >= 1 && val <= 12) : (val <= 23));
    if (ld && ok) begin
      nh = m12 ? ((val % 12) + (lpm ? 12 : 0)) : val;
    end else begin
      e = ld;
      if (tk) begin
        nh = (h + 1) % 24;
        c  = (h == 23);
      end
    end
  endfunction

  // Behavioural model, updated on the same edges as the design.
  always @(posedge clk or negedge rst) begin
    int nh, t, o;
    bit c, e, p;
    if (!rst) begin
      enc(RH, mode_12h, t, o, p);
      m_h <= RH;
      e_t <= t; e_o <= o; e_p <= p; e_c <= 1'b0; e_e <= 1'b0;
    end else begin
      step(m_h, tick, load, mode_12h, int'(load_tens), int'(load_ones),
           load_pm, nh, c, e);
      enc(nh, mode_12h, t, o, p);
      m_h <= nh;
      e_t <= t; e_o <= o; e_p <= p; e_c <= c; e_e <= e;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_tens", int'(hour_tens), e_t);
      chk("model_ones", int'(hour_ones), e_o);
      chk("model_pm",   int'(pm),        int'(e_p));
      chk("model_carry", int'(day_carry), int'(e_c));
      chk("model_err",  int'(load_err),  int'(e_e));
    end
  end

  task automatic lit(input string name, input int t, input int o,
                     input int p, input int c, input int e);
    chk({name, ".tens"},  int'(hour_tens), t);
    chk({name, ".ones"},  int'(hour_ones), o);
    chk({name, ".pm"},    int'(pm),        p);
    chk({name, ".carry"}, int'(day_carry), c);
    chk({name, ".err"},   int'(load_err),  e);
  endtask

  // Advance n clocks, returning at a falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_load(input bit ld, input int t, input int o, input bit p);
    load      = ld;
    load_tens = DW'(t);
    load_ones = DW'(o);
    load_pm   = p;
  endtask

  task automatic do_reset(input string name, input int t, input int o);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 lit(name, t, o, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  // directed mixed vectors: {tick, mode_12h, load, tens, ones, load_pm}
  typedef struct {
    bit tk; bit m; bit ld; int t; int o; bit p;
  } vec_t;
  vec_t vecs[10];

  initial begin
    rst = 1'b0; tick = 1'b0; mode_12h = 1'b0;
    set_load(1'b0, 0, 0, 1'b0);

    // reset, 24h
    repeat (2) @(negedge clk);
    lit("rst24", 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // 24 ticks through the day
    tick = 1'b1;
    cyc(23); lit("t23", 2, 3, 1, 0, 0);
    cyc(1);  lit("wrap24", 0, 0, 0, 1, 0);
    tick = 1'b0;
    cyc(1);  lit("carry_one_cycle", 0, 0, 0, 0, 0);

    // 12h rollover
    mode_12h = 1'b1;
    do_reset("rst12", 1, 2);
    tick = 1'b1;
    cyc(11); lit("11am", 1, 1, 0, 0, 0);
    cyc(1);  lit("12pm", 1, 2, 1, 0, 0);
    cyc(11); lit("11pm", 1, 1, 1, 0, 0);
    cyc(1);  lit("12am", 1, 2, 0, 1, 0);
    tick = 1'b0;

    // 24h loads
    mode_12h = 1'b0;
    set_load(1'b1, 2, 3, 1'b0);   cyc(1); lit("ld23", 2, 3, 1, 0, 0);
    set_load(1'b1, 2, 4, 1'b0);   cyc(1); lit("ld24_rej", 2, 3, 1, 0, 1);
    set_load(1'b1, 1, 10, 1'b0);  cyc(1); lit("ld1A_rej", 2, 3, 1, 0, 1);
    set_load(1'b1, 16, 1, 1'b0);  cyc(1); lit("ld_upper_rej", 2, 3, 1, 0, 1);
    set_load(1'b0, 0, 0, 1'b0);   cyc(1); lit("err_one_cycle", 2, 3, 1, 0, 0);

    // 12h loads
    mode_12h = 1'b1;
    set_load(1'b1, 1, 2, 1'b0);   cyc(1); lit("ld12am", 1, 2, 0, 0, 0);
    set_load(1'b1, 0, 0, 1'b0);   cyc(1); lit("ld00_rej", 1, 2, 0, 0, 1);
    set_load(1'b1, 0, 7, 1'b1);   cyc(1); lit("ld07pm", 0, 7, 1, 0, 0);
    set_load(1'b0, 0, 0, 1'b0);
    mode_12h = 1'b0;              cyc(1); lit("mode_to24", 1, 9, 1, 0, 0);

    // priority
    set_load(1'b1, 2, 3, 1'b0);   cyc(1);
    set_load(1'b1, 0, 5, 1'b0); tick = 1'b1;
    cyc(1); lit("load_over_tick", 0, 5, 0, 0, 0);
    set_load(1'b1, 2, 2, 1'b0); tick = 1'b0; cyc(1);
    set_load(1'b1, 9, 9, 1'b0); tick = 1'b1;
    cyc(1); lit("rej_load_tick", 2, 3, 1, 0, 1);
    set_load(1'b1, 0, 0, 1'b0); tick = 1'b0;
    cyc(1); lit("load0_no_carry", 0, 0, 0, 0, 0);

    // async reset mid-count
    set_load(1'b1, 1, 5, 1'b0);   cyc(1);
    set_load(1'b0, 0, 0, 1'b0);   lit("at15", 1, 5, 1, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 lit("async_rst", 0, 0, 0, 0, 0);
    tick = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    lit("release_tick", 0, 1, 0, 0, 0);
    tick = 1'b0;

    // mixed directed vectors, checked by the model each cycle
    vecs[0] = '{1, 1, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 1, 1, 1, 1};
    vecs[2] = '{1, 1, 0, 0, 0, 0};
    vecs[3] = '{1, 0, 1, 1, 3, 0};
    vecs[4] = '{0, 0, 1, 3, 0, 0};
    vecs[5] = '{1, 1, 1, 1, 3, 1};
    vecs[6] = '{0, 0, 1, 1, 9, 0};
    vecs[7] = '{1, 0, 0, 0, 0, 0};
    vecs[8] = '{0, 1, 1, 0, 9, 0};
    vecs[9] = '{1, 1, 1, 0, 0, 1};
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        tick     = vecs[i].tk;
        mode_12h = vecs[i].m;
        set_load(vecs[i].ld, vecs[i].t, vecs[i].o, vecs[i].p);
        cyc(1);
      end
    end
    tick = 1'b0;
    set_load(1'b0, 0, 0, 1'b0);
    cyc(2);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hour_counter_bcd
`default_nettype wire
